// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm setting block.
// BCD digit, editor state, 24h limits and the packed hh:mm bundle.
package alarm_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2
    } edit_state_t;

    localparam int unsigned MAX_HOUR = 23;
    localparam int unsigned MAX_MIN  = 59;

    // Digit-wise limits used by the BCD adder.
    localparam bcd_t MAX_HOUR_DEC = 4'(MAX_HOUR / 10);
    localparam bcd_t MAX_HOUR_ONE = 4'(MAX_HOUR % 10);
    localparam bcd_t MAX_MIN_DEC  = 4'(MAX_MIN / 10);

    typedef struct packed {
        bcd_t hourdec;
        bcd_t hourone;
        bcd_t mindec;
        bcd_t minone;
    } hhmm_t;

    // Binary hour/minute to BCD; used for the reset constant.
    function automatic hhmm_t to_hhmm(
        input int unsigned h,
        input int unsigned m
    );
        hhmm_t t;
        t.hourdec = 4'(h / 10);
        t.hourone = 4'(h % 10);
        t.mindec  = 4'(m / 10);
        t.minone  = 4'(m % 10);
        return t;
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational BCD hh:mm adder: adds 0..9 minutes (optionally carrying
// into the hour) and/or one hour; the result wraps at 59 min / 23 h.
// Ports: t_in, min_inc, hour_carry_en, hour_inc -> t_out.
module bcd_time_add
    import alarm_pkg::*;
(
    input  hhmm_t t_in,
    input  bcd_t  min_inc,
    input  logic  hour_carry_en,
    input  logic  hour_inc,
    output hhmm_t t_out
);

    logic [4:0] one_sum;
    bcd_t       dec_sum;
    logic       min_wrap;
    logic       hour_step;

    always_comb begin
        t_out   = t_in;
        one_sum = {1'b0, t_in.minone} + {1'b0, min_inc};
        dec_sum = t_in.mindec;

        // Minute ones digit, carry into tens.
        if (one_sum >= 5'd10) begin
            t_out.minone = 4'(one_sum - 5'd10);
            dec_sum      = t_in.mindec + 4'd1;
        end else begin
            t_out.minone = one_sum[3:0];
        end

        // Minute tens past 5 means the minute rolled over 59.
        min_wrap     = (dec_sum > MAX_MIN_DEC);
        t_out.mindec = min_wrap ? 4'd0 : dec_sum;

        hour_step = hour_inc | (hour_carry_en & min_wrap);

        if (hour_step) begin
            if (t_in.hourdec == MAX_HOUR_DEC &&
                t_in.hourone == MAX_HOUR_ONE) begin
                t_out.hourdec = 4'd0;
                t_out.hourone = 4'd0;
            end else if (t_in.hourone == 4'd9) begin
                t_out.hourdec = t_in.hourdec + 4'd1;
                t_out.hourone = 4'd0;
            end else begin
                t_out.hourone = t_in.hourone + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_setter.sv
// Alarm time editor: edit hours then minutes, arm/disarm, and snooze.
// Ports: clk_sec/rstn; btn_* pulses, aud_en in; *_bud, bud_on, disp_*,
// edit_state out (all registered).
module alarm_setter
    import alarm_pkg::*;
#(
    parameter int unsigned RST_HOUR    = 7,
    parameter int unsigned RST_MIN     = 0,
    parameter int unsigned TIMEOUT_SEC = 30,
    parameter int unsigned SNOOZE_MIN  = 5
) (
    input  logic       clk_sec,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic       btn_snooze,
    input  logic       aud_en,
    output logic [3:0] hourdec_bud,
    output logic [3:0] hourone_bud,
    output logic [3:0] mindec_bud,
    output logic [3:0] minone_bud,
    output logic       bud_on,
    output logic [3:0] disp_hourdec,
    output logic [3:0] disp_hourone,
    output logic [3:0] disp_mindec,
    output logic [3:0] disp_minone,
    output logic [1:0] edit_state
);

    localparam hhmm_t      RST_TIME = to_hhmm(RST_HOUR, RST_MIN);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_SEC - 1);
    localparam bcd_t       SNZ_INC  = 4'(SNOOZE_MIN);

    edit_state_t state_q,  state_d;
    hhmm_t       commit_q, commit_d;
    hhmm_t       shadow_q, shadow_d;
    hhmm_t       disp_q,   disp_d;
    logic        bud_on_q, bud_on_d;
    logic [7:0]  tmo_q,    tmo_d;

    hhmm_t add_src;
    bcd_t  add_min;
    logic  add_carry;
    logic  add_hour;
    hhmm_t add_sum;

    logic edit_btn;
    logic tmo_hit;

    // One adder serves all three paths; the state picks the operands
    // because only one path can be active in any state.
    always_comb begin
        add_src   = shadow_q;
        add_min   = 4'd0;
        add_carry = 1'b0;
        add_hour  = 1'b0;
        unique case (state_q)
            IDLE: begin
                add_src   = commit_q;
                add_min   = SNZ_INC;
                add_carry = 1'b1;
            end
            EDIT_HOUR: add_hour = 1'b1;
            EDIT_MIN:  add_min  = 4'd1;
            default: ;
        endcase
    end

    bcd_time_add u_add (
        .t_in          (add_src),
        .min_inc       (add_min),
        .hour_carry_en (add_carry),
        .hour_inc      (add_hour),
        .t_out         (add_sum)
    );

    assign edit_btn = btn_mode | btn_inc;
    assign tmo_hit  = (tmo_q == TMO_LAST) && !edit_btn;

    always_comb begin
        state_d  = state_q;
        commit_d = commit_q;
        shadow_d = shadow_q;
        bud_on_d = bud_on_q;
        tmo_d    = edit_btn ? 8'd0 : tmo_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                tmo_d = 8'd0;
                if (btn_mode) begin
                    state_d  = EDIT_HOUR;
                    shadow_d = commit_q;
                end else if (btn_alarm) begin
                    bud_on_d = ~bud_on_q;
                end else if (btn_snooze && aud_en && bud_on_q) begin
                    commit_d = add_sum;
                end
            end
            EDIT_HOUR: begin
                if (btn_mode) begin
                    state_d = EDIT_MIN;
                end else if (btn_inc) begin
                    shadow_d = add_sum;
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    shadow_d = commit_q;
                    tmo_d    = 8'd0;
                end
            end
            EDIT_MIN: begin
                if (btn_mode) begin
                    state_d  = IDLE;
                    commit_d = shadow_q;
                    bud_on_d = 1'b1;
                end else if (btn_inc) begin
                    shadow_d = add_sum;
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    shadow_d = commit_q;
                    tmo_d    = 8'd0;
                end
            end
            default: begin
                state_d  = IDLE;
                shadow_d = commit_q;
                tmo_d    = 8'd0;
            end
        endcase

        // Display follows the state being entered so it stays registered.
        disp_d = (state_d == IDLE) ? commit_d : shadow_d;
    end

    always_ff @(posedge clk_sec or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            commit_q <= RST_TIME;
            shadow_q <= RST_TIME;
            disp_q   <= RST_TIME;
            bud_on_q <= 1'b0;
            tmo_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            bud_on_q <= bud_on_d;
            tmo_q    <= tmo_d;
        end
    end

    assign hourdec_bud  = commit_q.hourdec;
    assign hourone_bud  = commit_q.hourone;
    assign mindec_bud   = commit_q.mindec;
    assign minone_bud   = commit_q.minone;
    assign bud_on       = bud_on_q;
    assign disp_hourdec = disp_q.hourdec;
    assign disp_hourone = disp_q.hourone;
    assign disp_mindec  = disp_q.mindec;
    assign disp_minone  = disp_q.minone;
    assign edit_state   = state_q;

endmodule
